// File: rtl/axis_pack.sv
// AXI-stream width up-converter: packs RATIO narrow beats into one wide word, LSB lane first.
// Define AXIS_PACK_KEEP_EN to add the m_axis_tkeep lane-valid mask.
module axis_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH*RATIO-1:0] m_axis_tdata,
`ifdef AXIS_PACK_KEEP_EN
    output logic                        m_axis_tlast,
    output logic [RATIO-1:0]            m_axis_tkeep
`else
    output logic                        m_axis_tlast
`endif
);

    localparam int WORD_W = DATA_WIDTH * RATIO;
    localparam int CNT_W  = $clog2(RATIO);

    // Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
    // valid never waits on ready, and a raised valid holds its payload until the transfer.
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] word;
    logic              beat;
    logic              closing;

    // The output register is the only buffer, so input stalls only while it holds a word.
    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign closing       = (cnt == CNT_W'(RATIO - 1)) | s_axis_tlast;

    // Lanes above cnt are still zero in acc, so a partial flush is zero-padded for free.
    always_comb begin
        word = acc;
        word[cnt*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
    end

`ifdef AXIS_PACK_KEEP_EN
    logic [RATIO-1:0] keep;

    always_comb begin
        keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            keep[i] = (CNT_W'(i) <= cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tkeep <= '0;
        end else if (beat && closing) begin
            m_axis_tkeep <= keep;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            cnt           <= '0;
            acc           <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            // A closing beat overrides the drop above, giving back-to-back words with no bubble.
            if (beat) begin
                if (closing) begin
                    m_axis_tdata  <= word;
                    m_axis_tlast  <= s_axis_tlast;
                    m_axis_tvalid <= 1'b1;
                    cnt           <= '0;
                    acc           <= '0;
                end else begin
                    acc <= word;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
